ad7656_cfg_writer: RTL and testbench

Write-side companion to the AD7656 read driver. It drives the AD7656 parallel bus in the write direction (CS_n, WR_n and DB output enable) to load the 16-bit control word into the converter. It arbitrates bus ownership with the per-ADC read driver through a request/grant handshake. It optionally issues an ADC reset pulse first. One instance per ADC sits beside each read driver in the ADC wrapper; the wrapper merges cs_n/reset and owns the DB tristate.

---
 rtl/ad7656_cfg_writer.sv | 170 +++++++++++++++++
 tb/tb_ad7656_cfg_writer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad7656_cfg_writer.sv
// AD7656 control-word writer: optional ADC reset, bus request/grant, then CS_n/WR_n write strobes.
// Optional macro AD7656_CFG_RESET_EN builds the RST_PULSE/RST_WAIT reset phase ahead of each write.
module ad7656_cfg_writer #(
  parameter int T_RST_PULSE = 10,
  parameter int T_RST_WAIT  = 50,
  parameter int T_CS_SETUP  = 2,
  parameter int T_WR_LOW    = 3,
  parameter int T_HOLD      = 2,
  parameter int NUM_WRITES  = 1
) (
  input  logic        sys_clk_i,
  input  logic        rst_n_i,
  input  logic        cfg_req_i,
  input  logic [15:0] cfg_word_i,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        bus_req_o,
  input  logic        bus_gnt_i,
  output logic        adc_reset_o,
  output logic        cs_n_o,
  output logic        wr_n_o,
  output logic [15:0] db_o,
  output logic        db_oe_o
);

  // Handshake: bus_req_o rises on entering REQ_BUS and stays high until RELEASE;
  // a high bus_gnt_i seen in REQ_BUS starts the write, later grant changes are ignored.
  typedef enum logic [3:0] {
    IDLE, RST_PULSE, RST_WAIT, REQ_BUS, CS_SETUP, WR_LOW, WR_HOLD, RELEASE, DONE
  } state_t;

`ifdef AD7656_CFG_RESET_EN
  localparam logic [7:0] RSTP_LAST = 8'(((T_RST_PULSE < 1) ? 1 : T_RST_PULSE) - 1);
  localparam logic [7:0] RSTW_LAST = 8'(((T_RST_WAIT  < 1) ? 1 : T_RST_WAIT)  - 1);
`endif
  localparam logic [7:0] CS_LAST   = 8'(((T_CS_SETUP  < 1) ? 1 : T_CS_SETUP)  - 1);
  localparam logic [7:0] WR_LAST   = 8'(((T_WR_LOW    < 1) ? 1 : T_WR_LOW)    - 1);
  localparam logic [7:0] HOLD_LAST = 8'(((T_HOLD      < 1) ? 1 : T_HOLD)      - 1);
  localparam logic [2:0] NW        = 3'((NUM_WRITES < 1) ? 1 : (NUM_WRITES > 4) ? 4 : NUM_WRITES);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  wr_cnt_q, wr_cnt_d;
  logic [15:0] word_q, word_d;
  logic        busy_q, busy_d, done_q, done_d, bus_req_q, bus_req_d;
  logic        adc_reset_q, adc_reset_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d, db_oe_q, db_oe_d;
  logic [15:0] db_q, db_d;
  logic        drive;

  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      wr_cnt_q    <= 3'd0;
      word_q      <= 16'h0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bus_req_q   <= 1'b0;
      adc_reset_q <= 1'b0;
      cs_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      db_q        <= 16'h0000;
      db_oe_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bus_req_q   <= bus_req_d;
      adc_reset_q <= adc_reset_d;
      cs_n_q      <= cs_n_d;
      wr_n_q      <= wr_n_d;
      db_q        <= db_d;
      db_oe_q     <= db_oe_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_cnt_d = wr_cnt_q;
    word_d   = word_q;
    case (state_q)
      IDLE: begin
        if (cfg_req_i) begin
          word_d = cfg_word_i;
          cnt_d  = 8'd0;
`ifdef AD7656_CFG_RESET_EN
          state_d = RST_PULSE;
`else
          state_d = REQ_BUS;
`endif
        end
      end
`ifdef AD7656_CFG_RESET_EN
      RST_PULSE: begin
        if (cnt_q == RSTP_LAST) begin
          cnt_d   = 8'd0;
          state_d = RST_WAIT;
        end else cnt_d = cnt_q + 8'd1;
      end
      RST_WAIT: begin
        if (cnt_q == RSTW_LAST) begin
          cnt_d   = 8'd0;
          state_d = REQ_BUS;
        end else cnt_d = cnt_q + 8'd1;
      end
`endif
      REQ_BUS: begin
        if (bus_gnt_i) begin
          cnt_d    = 8'd0;
          wr_cnt_d = 3'd0;
          state_d  = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (cnt_q == CS_LAST) begin
          cnt_d   = 8'd0;
          state_d = WR_LOW;
        end else cnt_d = cnt_q + 8'd1;
      end
      WR_LOW: begin
        if (cnt_q == WR_LAST) begin
          cnt_d   = 8'd0;
          state_d = WR_HOLD;
        end else cnt_d = cnt_q + 8'd1;
      end
      WR_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d    = 8'd0;
          wr_cnt_d = wr_cnt_q + 3'd1;
          // Repeat writes keep CS_n low by looping straight back to CS_SETUP.
          state_d  = (wr_cnt_d < NW) ? CS_SETUP : RELEASE;
        end else cnt_d = cnt_q + 8'd1;
      end
      RELEASE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    drive     = (state_d == CS_SETUP) || (state_d == WR_LOW) || (state_d == WR_HOLD);
    busy_d    = (state_d != IDLE) && (state_d != DONE);
    done_d    = (state_d == DONE);
    bus_req_d = drive || (state_d == REQ_BUS);
    cs_n_d    = !drive;
    wr_n_d    = (state_d != WR_LOW);
    db_oe_d   = drive;
    db_d      = drive ? word_d : 16'h0000;
`ifdef AD7656_CFG_RESET_EN
    adc_reset_d = (state_d == RST_PULSE);
`else
    adc_reset_d = 1'b0;
`endif
  end

  assign cfg_busy_o  = busy_q;
  assign cfg_done_o  = done_q;
  assign bus_req_o   = bus_req_q;
  assign adc_reset_o = adc_reset_q;
  assign cs_n_o      = cs_n_q;
  assign wr_n_o      = wr_n_q;
  assign db_o        = db_q;
  assign db_oe_o     = db_oe_q;

endmodule

// File: tb/tb_ad7656_cfg_writer.sv
// Self-checking bench for ad7656_cfg_writer (NUM_WRITES=3); follows AD7656_CFG_RESET_EN if defined.
module tb_ad7656_cfg_writer;

  localparam int T_RST_PULSE = 10;
  localparam int T_RST_WAIT  = 50;
  localparam int T_CS_SETUP  = 2;
  localparam int T_WR_LOW    = 3;
  localparam int T_HOLD      = 2;
  localparam int NW          = 3;
`ifdef AD7656_CFG_RESET_EN
  localparam int RST_HI  = T_RST_PULSE;
  localparam int RST_ALL = T_RST_PULSE + T_RST_WAIT;
`else
  localparam int RST_HI  = 0;
  localparam int RST_ALL = 0;
`endif
  // Cycles from driving the request to WR_n low: accept edge, reset phase, grant edge, setup.
  localparam int LAT = 1 + RST_ALL + 1 + T_CS_SETUP;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_req = 1'b0;
  logic [15:0] cfg_word = 16'h0000;
  logic        bus_gnt = 1'b1;
  logic        cfg_busy, cfg_done, bus_req, adc_reset, cs_n, wr_n, db_oe;
  logic [15:0] db;

  int n_checks = 0;
  int n_err = 0;

  ad7656_cfg_writer #(
    .T_RST_PULSE(T_RST_PULSE), .T_RST_WAIT(T_RST_WAIT), .T_CS_SETUP(T_CS_SETUP),
    .T_WR_LOW(T_WR_LOW), .T_HOLD(T_HOLD), .NUM_WRITES(NW)
  ) dut (
    .sys_clk_i(clk), .rst_n_i(rst_n), .cfg_req_i(cfg_req), .cfg_word_i(cfg_word),
    .cfg_busy_o(cfg_busy), .cfg_done_o(cfg_done), .bus_req_o(bus_req), .bus_gnt_i(bus_gnt),
    .adc_reset_o(adc_reset), .cs_n_o(cs_n), .wr_n_o(wr_n), .db_o(db), .db_oe_o(db_oe)
  );

  // Clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Bus monitor: logs what the ADC would see; tasks take deltas of these totals.
  logic [15:0] obs_q[$];
  int          wl_q[$];
  logic [15:0] exp_q[$];
  logic [15:0] cur_word = 16'h0000;
  int done_total = 0, rsthi_total = 0, cs_falls = 0, bad_cs = 0, cur_w = 0;
  logic prev_wr_n = 1'b1, prev_cs_n = 1'b1;

  always @(negedge clk) begin
    if (prev_wr_n && !wr_n) obs_q.push_back(db);
    if (!wr_n) cur_w = cur_w + 1;
    if (!prev_wr_n && wr_n) begin
      wl_q.push_back(cur_w);
      cur_w = 0;
    end
    if (prev_cs_n && !cs_n) cs_falls = cs_falls + 1;
    if (!cs_n && (db_oe !== 1'b1 || db !== cur_word || bus_req !== 1'b1)) bad_cs = bad_cs + 1;
    if (cfg_done) done_total = done_total + 1;
    if (adc_reset) rsthi_total = rsthi_total + 1;
    prev_wr_n = wr_n;
    prev_cs_n = cs_n;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [15:0] w);
    cfg_word = w;
    cfg_req  = 1'b1;
    tick();
    cfg_req  = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (cfg_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({cfg_busy, cfg_done, bus_req, adc_reset, cs_n, wr_n, db_oe} !== 7'b0000110) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 0000110", {cfg_busy, cfg_done, bus_req, adc_reset, cs_n, wr_n, db_oe});
    end
    n_checks++;
    if (db !== 16'h0000) begin
      n_err++;
      $display("FAIL reset_db: got %h required 0000", db);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single(input logic [15:0] w);
    int i0, w0, d0, r0, c0, b0, lat;
    bit ok;
    logic [15:0] e;
    i0 = obs_q.size(); w0 = wl_q.size(); d0 = done_total; r0 = rsthi_total;
    c0 = cs_falls; b0 = bad_cs;
    cur_word = w;
    bus_gnt  = 1'b1;
    send_req(w);
    n_checks++;
    if (cfg_busy !== 1'b1) begin
      n_err++;
      $display("FAIL single_busy: got %b required 1", cfg_busy);
    end
    lat = 1;
    while (wr_n === 1'b1 && lat < 1000) begin
      tick();
      lat++;
    end
    n_checks++;
    if (lat != LAT) begin
      n_err++;
      $display("FAIL single_latency: got %0d required %0d", lat, LAT);
    end
    wait_done(ok);
    n_checks++;
    if (!ok || cfg_busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_done: got done_seen=%0d busy=%b required 1/0", ok, cfg_busy);
    end
    tick();
    n_checks++;
    if (done_total - d0 != 1 || cfg_done !== 1'b0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL single_pulse: got pulses=%0d done=%b bus_req=%b required 1/0/0", done_total - d0, cfg_done, bus_req);
    end
    n_checks++;
    if (rsthi_total - r0 != RST_HI) begin
      n_err++;
      $display("FAIL single_adc_reset: got %0d cycles required %0d", rsthi_total - r0, RST_HI);
    end
    n_checks++;
    if (cs_falls - c0 != 1 || bad_cs - b0 != 0) begin
      n_err++;
      $display("FAIL single_cs: got falls=%0d bad=%0d required 1/0", cs_falls - c0, bad_cs - b0);
    end
    for (int k = 0; k < NW; k++) exp_q.push_back(w);
    for (int k = 0; k < NW; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (i0 + k >= obs_q.size() || obs_q[i0 + k] !== e) begin
        n_err++;
        $display("FAIL single_word%0d: got %h required %h", k, (i0 + k < obs_q.size()) ? obs_q[i0 + k] : 16'hxxxx, e);
      end
    end
    n_checks++;
    if (wl_q.size() - w0 != NW) begin
      n_err++;
      $display("FAIL single_wr_pulses: got %0d required %0d", wl_q.size() - w0, NW);
    end
    for (int k = w0; k < wl_q.size(); k++) begin
      n_checks++;
      if (wl_q[k] != T_WR_LOW) begin
        n_err++;
        $display("FAIL single_wr_width: got %0d required %0d", wl_q[k], T_WR_LOW);
      end
    end
  endtask

  task automatic test_no_grant();
    int bad, n;
    bit ok;
    cur_word = 16'h5A3C;
    bus_gnt  = 1'b0;
    send_req(16'h5A3C);
    n = 0;
    while (bus_req !== 1'b1 && n < 500) begin
      tick();
      n++;
    end
    bad = 0;
    for (int k = 0; k < 200; k++) begin
      if (cs_n !== 1'b1 || db_oe !== 1'b0 || bus_req !== 1'b1 || wr_n !== 1'b1) bad++;
      tick();
    end
    n_checks++;
    if (n >= 500 || bad != 0) begin
      n_err++;
      $display("FAIL nogrant_hold: got wait=%0d bad_cycles=%0d required <500/0", n, bad);
    end
    bus_gnt = 1'b1;
    tick();
    n_checks++;
    if (cs_n !== 1'b0 || db_oe !== 1'b1 || db !== 16'h5A3C) begin
      n_err++;
      $display("FAIL nogrant_cs_fall: got cs_n=%b oe=%b db=%h required 0/1/5a3c", cs_n, db_oe, db);
    end
    wait_done(ok);
    tick();
  endtask

  task automatic test_back_to_back();
    int i0, d0, n;
    bit ok;
    logic [15:0] w1, w3, e;
    w1 = 16'h1234;
    w3 = 16'($urandom);
    i0 = obs_q.size(); d0 = done_total;
    cur_word = w1;
    bus_gnt  = 1'b1;
    send_req(w1);
    n = 0;
    while (wr_n !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    send_req(16'hFFFF);
    wait_done(ok);
    // Request in the DONE cycle must be ignored.
    send_req(16'hFFFF);
    n_checks++;
    if (!ok || cfg_busy !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done_cycle_req: got done_seen=%0d busy=%b required 1/0", ok, cfg_busy);
    end
    n_checks++;
    if (done_total - d0 != 1) begin
      n_err++;
      $display("FAIL b2b_one_done: got %0d required 1", done_total - d0);
    end
    for (int k = 0; k < NW; k++) exp_q.push_back(w1);
    cur_word = w3;
    send_req(w3);
    n_checks++;
    if (cfg_busy !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_after_done_req: got busy=%b required 1", cfg_busy);
    end
    wait_done(ok);
    tick();
    for (int k = 0; k < NW; k++) exp_q.push_back(w3);
    n_checks++;
    if (obs_q.size() - i0 != 2 * NW) begin
      n_err++;
      $display("FAIL b2b_count: got %0d writes required %0d", obs_q.size() - i0, 2 * NW);
    end
    for (int k = 0; k < 2 * NW; k++) begin
      e = exp_q.pop_front();
      n_checks++;
      if (i0 + k >= obs_q.size() || obs_q[i0 + k] !== e) begin
        n_err++;
        $display("FAIL b2b_word%0d: got %h required %h", k, (i0 + k < obs_q.size()) ? obs_q[i0 + k] : 16'hxxxx, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n, i0;
    bit ok;
    cur_word = 16'hC3C3;
    bus_gnt  = 1'b1;
    send_req(16'hC3C3);
    n = 0;
    while (wr_n !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (n >= 500 || wr_n !== 1'b1 || cs_n !== 1'b1 || db_oe !== 1'b0 || bus_req !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_async: got wr_n=%b cs_n=%b oe=%b req=%b required 1/1/0/0", wr_n, cs_n, db_oe, bus_req);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    n_checks++;
    if (cfg_busy !== 1'b0 || cs_n !== 1'b1 || db !== 16'h0000) begin
      n_err++;
      $display("FAIL rstmid_idle: got busy=%b cs_n=%b db=%h required 0/1/0000", cfg_busy, cs_n, db);
    end
    i0 = obs_q.size();
    cur_word = 16'h0F0F;
    send_req(16'h0F0F);
    wait_done(ok);
    tick();
    n_checks++;
    if (!ok || obs_q.size() - i0 != NW || obs_q[i0] !== 16'h0F0F) begin
      n_err++;
      $display("FAIL rstmid_restart: got done=%0d writes=%0d required 1/%0d", ok, obs_q.size() - i0, NW);
    end
  endtask

  task automatic test_random();
    int i0, gd, n, bad;
    bit ok;
    logic [15:0] w, e;
    for (int t = 0; t < 6; t++) begin
      w  = 16'($urandom);
      gd = $urandom_range(0, 20);
      i0 = obs_q.size();
      cur_word = w;
      bus_gnt  = 1'b0;
      send_req(w);
      n = 0;
      while (bus_req !== 1'b1 && n < 500) begin
        tick();
        n++;
      end
      bad = 0;
      repeat (gd) begin
        if (cs_n !== 1'b1) bad++;
        tick();
      end
      bus_gnt = 1'b1;
      tick();
      // Dropping grant mid-write must not abort it.
      bus_gnt = ($urandom_range(0, 1) == 1);
      wait_done(ok);
      bus_gnt = 1'b1;
      tick();
      n_checks++;
      if (!ok || bad != 0) begin
        n_err++;
        $display("FAIL rand%0d_flow: got done=%0d early_cs=%0d required 1/0", t, ok, bad);
      end
      for (int k = 0; k < NW; k++) exp_q.push_back(w);
      for (int k = 0; k < NW; k++) begin
        e = exp_q.pop_front();
        n_checks++;
        if (i0 + k >= obs_q.size() || obs_q[i0 + k] !== e) begin
          n_err++;
          $display("FAIL rand%0d_word%0d: got %h required %h", t, k, (i0 + k < obs_q.size()) ? obs_q[i0 + k] : 16'hxxxx, e);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(16'h00A5);
    test_single(16'($urandom));
    test_no_grant();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_checks++;
    if (bad_cs != 0) begin
      n_err++;
      $display("FAIL cs_window_total: got %0d bad cycles required 0", bad_cs);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
